// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the framer state encoding.
package eth_pkg;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
    localparam int         ETH_MAX_FRAME     = 1522;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } rx_framer_state_e;

endpackage

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: validates and strips preamble/SFD, emits DA..FCS bytes
// through a one-byte hold stage so eof lands on the last byte itself.
module gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PREAMBLE    = 1,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME,
    parameter int LEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       gmii_rxd_i,
    input  logic             gmii_rx_dv_i,
    input  logic             gmii_rx_er_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             err_o,
    output logic [LEN_W-1:0] len_o,
    output logic [15:0]      drop_cnt_o
);

    localparam logic [3:0]       MIN_PRE = 4'(MIN_PREAMBLE);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

    rx_framer_state_e state_q;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_flag_q;
    logic             first_q;

    logic [7:0]       hold_data_q;
    logic             hold_valid_q;
    logic             hold_sof_q;

    logic [7:0]       data_q;
    logic             valid_q, sof_q, eof_q, err_q;
    logic [LEN_W-1:0] len_out_q;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    // Saturating increments shared by the state machine below.
    always_comb begin
        len_d      = (len_q == '1) ? len_q : len_q + LEN_W'(1);
        pre_cnt_d  = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    end

    // NOTE: every register here, including the hold byte, uses <= so all
    // state updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pre_cnt_q    <= '0;
            len_q        <= '0;
            err_flag_q   <= 1'b0;
            first_q      <= 1'b0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_sof_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            err_q        <= 1'b0;
            len_out_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (gmii_rx_dv_i) begin
                        if (gmii_rxd_i == ETH_PREAMBLE_BYTE) begin
                            state_q   <= PREAMBLE;
                            pre_cnt_q <= 4'd1;
                        end else begin
                            state_q    <= DROP;
                            drop_cnt_q <= drop_cnt_d;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv_i) begin
                        state_q    <= IDLE;
                        drop_cnt_q <= drop_cnt_d;
                    end else if (gmii_rx_er_i) begin
                        state_q    <= DROP;
                        drop_cnt_q <= drop_cnt_d;
                    end else if (gmii_rxd_i == ETH_PREAMBLE_BYTE) begin
                        pre_cnt_q <= pre_cnt_d;
                    end else if (gmii_rxd_i == ETH_SFD_BYTE && pre_cnt_q >= MIN_PRE) begin
                        state_q      <= PAYLOAD;
                        len_q        <= '0;
                        err_flag_q   <= 1'b0;
                        first_q      <= 1'b1;
                        hold_valid_q <= 1'b0;
                    end else begin
                        state_q    <= DROP;
                        drop_cnt_q <= drop_cnt_d;
                    end
                end

                PAYLOAD: begin
                    if (gmii_rx_dv_i) begin
                        if (hold_valid_q) begin
                            valid_q <= 1'b1;
                            data_q  <= hold_data_q;
                            sof_q   <= hold_sof_q;
                        end
                        hold_data_q  <= gmii_rxd_i;
                        hold_valid_q <= 1'b1;
                        hold_sof_q   <= first_q;
                        first_q      <= 1'b0;
                        len_q        <= len_d;
                        if (gmii_rx_er_i || len_d > MAX_LEN)
                            err_flag_q <= 1'b1;
                    end else begin
                        // dv falling flushes the held byte as the frame's last.
                        if (hold_valid_q) begin
                            valid_q   <= 1'b1;
                            data_q    <= hold_data_q;
                            sof_q     <= hold_sof_q;
                            eof_q     <= 1'b1;
                            err_q     <= err_flag_q;
                            len_out_q <= len_q;
                        end
                        hold_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv_i)
                        state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign sof_o      = sof_q;
    assign eof_o      = eof_q;
    assign err_o      = err_q;
    assign len_o      = len_out_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed self-checking bench for gmii_rx_framer.
module tb_gmii_rx_framer;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       gmii_rxd_i;
    logic             gmii_rx_dv_i;
    logic             gmii_rx_er_i;
    logic [7:0]       data_o;
    logic             valid_o, sof_o, eof_o, err_o;
    logic [LEN_W-1:0] len_o;
    logic [15:0]      drop_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_cyc = 0;
    int rst_cyc = -100;
    int stray = 0;
    logic [31:0] snap_valid, snap_data, snap_eof, snap_len;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]       data;
        logic             sof, eof, err;
        logic [LEN_W-1:0] len;
        int               cyc;
    } beat_t;
    beat_t cap[$];

    gmii_rx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rxd_i   (gmii_rxd_i),
        .gmii_rx_dv_i (gmii_rx_dv_i),
        .gmii_rx_er_i (gmii_rx_er_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .err_o        (err_o),
        .len_o        (len_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) cap.push_back('{data_o, sof_o, eof_o, err_o, len_o, cyc});
        if (!valid_o && (sof_o || eof_o)) stray++;
        if (cyc == rst_cyc + 1) begin
            snap_valid = 32'(valid_o);
            snap_data  = 32'(data_o);
            snap_eof   = 32'(eof_o);
            snap_len   = 32'(len_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        gmii_rx_dv_i = dv;
        gmii_rx_er_i = er;
        gmii_rxd_i   = d;
    endtask

    function automatic bq_t mk(input int n, input logic [7:0] start);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(start + 8'(i));
        return q;
    endfunction

    task automatic send_frame(input logic [7:0] sfd, input bq_t pay, input int er_idx,
                              input int rst_idx, input int ipg);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, sfd);
        for (int i = 0; i < pay.size(); i++) begin
            drive(1'b1, (i == er_idx), pay[i]);
            if (i == 0) first_cyc = cyc;
            if (i == rst_idx) begin
                rst     = 1'b1;
                rst_cyc = cyc;
            end
        end
        for (int i = 0; i < ipg; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic verify(input string tag, input int base, input bq_t exp, input logic exp_err,
                          input int exp_len, input int in_cyc);
        int n = exp.size();
        int bad_data = 0;
        int bad_gap = 0;
        int bad_mark = 0;
        check({tag, " present"}, 32'(cap.size() >= base + n), 32'd1);
        if (cap.size() < base + n) return;
        for (int i = 0; i < n; i++) begin
            if (cap[base+i].data !== exp[i]) bad_data++;
            if (cap[base+i].cyc != cap[base].cyc + i) bad_gap++;
            if (i > 0 && cap[base+i].sof) bad_mark++;
            if (i < n - 1 && cap[base+i].eof) bad_mark++;
        end
        check({tag, " data mismatches"}, 32'(bad_data), 32'd0);
        check({tag, " cadence gaps"}, 32'(bad_gap), 32'd0);
        check({tag, " misplaced sof/eof"}, 32'(bad_mark), 32'd0);
        check({tag, " sof first"}, 32'(cap[base].sof), 32'd1);
        check({tag, " eof last"}, 32'(cap[base+n-1].eof), 32'd1);
        check({tag, " err"}, 32'(cap[base+n-1].err), 32'(exp_err));
        check({tag, " len"}, 32'(cap[base+n-1].len), 32'(exp_len));
        check({tag, " latency"}, 32'(cap[base].cyc - in_cyc), 32'd2);
    endtask

    initial begin
        int f1;
        int bad;
        rst          = 1'b1;
        gmii_rx_dv_i = 1'b0;
        gmii_rx_er_i = 1'b0;
        gmii_rxd_i   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset sof", 32'(sof_o), 32'd0);
        check("reset eof", 32'(eof_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset data", 32'(data_o), 32'd0);
        check("reset len", 32'(len_o), 32'd0);
        check("reset drop", 32'(drop_cnt_o), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);

        // Good 64-byte frame.
        cap.delete();
        send_frame(8'hD5, mk(64, 8'h01), -1, -1, 4);
        check("good count", 32'(cap.size()), 32'd64);
        verify("good", 0, mk(64, 8'h01), 1'b0, 64, first_cyc);
        check("good drop", 32'(drop_cnt_o), 32'd0);

        // rx_er on payload byte 10.
        cap.delete();
        send_frame(8'hD5, mk(64, 8'h01), 9, -1, 4);
        check("rxer count", 32'(cap.size()), 32'd64);
        verify("rxer", 0, mk(64, 8'h01), 1'b1, 64, first_cyc);

        // Bad SFD, then a good frame.
        cap.delete();
        send_frame(8'hD4, mk(20, 8'h60), -1, -1, 4);
        check("badsfd count", 32'(cap.size()), 32'd0);
        check("badsfd drop", 32'(drop_cnt_o), 32'd1);
        send_frame(8'hD5, mk(64, 8'h21), -1, -1, 4);
        check("post badsfd count", 32'(cap.size()), 32'd64);
        verify("post badsfd", 0, mk(64, 8'h21), 1'b0, 64, first_cyc);
        check("post badsfd drop", 32'(drop_cnt_o), 32'd1);

        // 1-byte payload, 1-cycle IPG, then 64 bytes.
        cap.delete();
        send_frame(8'hD5, mk(1, 8'hAB), -1, -1, 1);
        f1 = first_cyc;
        send_frame(8'hD5, mk(64, 8'h80), -1, -1, 4);
        check("short+next count", 32'(cap.size()), 32'd65);
        verify("short", 0, mk(1, 8'hAB), 1'b0, 1, f1);
        verify("after short", 1, mk(64, 8'h80), 1'b0, 64, first_cyc);

        // Oversize boundary.
        cap.delete();
        send_frame(8'hD5, mk(1523, 8'h01), -1, -1, 4);
        check("1523 count", 32'(cap.size()), 32'd1523);
        verify("1523", 0, mk(1523, 8'h01), 1'b1, 1523, first_cyc);
        cap.delete();
        send_frame(8'hD5, mk(1522, 8'h01), -1, -1, 4);
        check("1522 count", 32'(cap.size()), 32'd1522);
        verify("1522", 0, mk(1522, 8'h01), 1'b0, 1522, first_cyc);

        // Reset during payload byte 30: bytes 1..28 were already out.
        cap.delete();
        send_frame(8'hD5, mk(64, 8'h01), -1, 29, 4);
        check("rst count", 32'(cap.size()), 32'd28);
        bad = 0;
        foreach (cap[i]) begin
            if (cap[i].data !== 8'(i + 1) || cap[i].eof || cap[i].cyc > rst_cyc) bad++;
        end
        check("rst pre-reset beats", 32'(bad), 32'd0);
        check("rst out valid", snap_valid, 32'd0);
        check("rst out data", snap_data, 32'd0);
        check("rst out eof", snap_eof, 32'd0);
        check("rst out len", snap_len, 32'd0);
        check("rst drop", 32'(drop_cnt_o), 32'd1);
        cap.delete();
        send_frame(8'hD5, mk(64, 8'h41), -1, -1, 4);
        check("post rst count", 32'(cap.size()), 32'd64);
        verify("post rst", 0, mk(64, 8'h41), 1'b0, 64, first_cyc);
        check("post rst drop", 32'(drop_cnt_o), 32'd1);

        check("stray sof/eof", 32'(stray), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
